aes_job_sequencer: RTL and testbench

Upstream command stage for the AES accelerator: queues encryption jobs (plaintext base, ciphertext base, block count, new-key flag) in a small FIFO and drives the accelerator's `start` / `new_key` / `plain_address` / `cipher_address` inputs. It issues one start pulse per 128-bit block and waits for the accelerator's `done` before each next block, stepping both addresses by a fixed stride. A `job_done` pulse is raised when a job's last block completes.

---
 rtl/aes_seq_pkg.sv | 24 ++
 rtl/aes_job_fifo.sv | 58 +++++
 rtl/aes_job_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_aes_job_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES job sequencer: FSM state encoding,
// job record width and the default per-block address stride.
package aes_seq_pkg;

  // Accelerator address width (word addresses, wraps modulo 4096).
  localparam int ADDR_W = 12;

  // One 128-bit block is four 32-bit words.
  localparam int DEFAULT_STRIDE = 4;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

  // Job record packed as {plain_addr, cipher_addr, blocks, new_key}.
  function automatic int job_width(input int cnt_w);
    return 2 * ADDR_W + cnt_w + 1;
  endfunction

endpackage

// File: rtl/aes_job_fifo.sv
// Synchronous job FIFO with full/empty/occupancy outputs.
// The read data is the head entry (show-ahead), valid whenever empty is low.
module aes_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aes_job_sequencer.sv
// AES job sequencer: queues jobs and issues one accelerator start per
// 128-bit block, stepping plaintext/ciphertext addresses by BLOCK_STRIDE.
// Accelerator-facing pulses (start, new_key, job_done, error) are registered.
// Optional watchdog: define AES_SEQ_TIMEOUT_EN to abort a job whose block
// does not complete within TIMEOUT_CYCLES cycles of WAIT.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 8,
  parameter int BLOCK_STRIDE   = DEFAULT_STRIDE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [ADDR_W-1:0]           job_plain_addr,
  input  logic [ADDR_W-1:0]           job_cipher_addr,
  input  logic [CNT_W-1:0]            job_blocks,
  input  logic                        job_new_key,
  output logic                        acc_start,
  output logic                        acc_new_key,
  output logic [ADDR_W-1:0]           acc_plain_address,
  output logic [ADDR_W-1:0]           acc_cipher_address,
  input  logic                        acc_done,
  output logic                        job_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] jobs_pending,
  output logic                        error
);

  localparam int JOB_W = job_width(CNT_W);

  seq_state_t        state_reg, state_next;
  logic [JOB_W-1:0]  fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              pop, step, finish, timeout_hit;

  logic [ADDR_W-1:0] head_plain, head_cipher;
  logic [CNT_W-1:0]  head_blocks;
  logic              head_new_key;

  logic [ADDR_W-1:0] plain_reg, cipher_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic              new_key_reg, first_reg;
  logic              start_reg, start_key_reg, job_done_reg;

  assign fifo_wdata = {job_plain_addr, job_cipher_addr, job_blocks, job_new_key};
  assign {head_plain, head_cipher, head_blocks, head_new_key} = fifo_rdata;

  aes_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (job_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (jobs_pending)
  );

  assign job_ready          = !fifo_full;
  assign busy               = (state_reg != IDLE);
  assign acc_start          = start_reg;
  assign acc_new_key        = start_key_reg;
  assign acc_plain_address  = plain_reg;
  assign acc_cipher_address = cipher_reg;
  assign job_done           = job_done_reg;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            error_reg;

  // A block completing on the last allowed cycle wins over the abort.
  assign timeout_hit = (state_reg == WAIT) && !acc_done &&
                       (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
  assign error       = error_reg;

  // Watchdog: counts cycles spent in WAIT, restarted by every block issue.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      error_reg <= timeout_hit;
      if (state_reg == ISSUE) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
    end
  end
`else
  // No watchdog: WAIT holds until the accelerator reports completion.
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (remaining_reg == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          if (remaining_reg == CNT_W'(1)) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            step       = 1'b1;
            state_next = ISSUE;
          end
        end else if (timeout_hit) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working registers: latch the popped job, count blocks, step addresses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      plain_reg     <= '0;
      cipher_reg    <= '0;
      remaining_reg <= '0;
      new_key_reg   <= 1'b0;
      first_reg     <= 1'b0;
    end else begin
      if (pop) begin
        plain_reg     <= head_plain;
        cipher_reg    <= head_cipher;
        remaining_reg <= head_blocks;
        new_key_reg   <= head_new_key;
        first_reg     <= 1'b1;
      end
      if (state_reg == ISSUE) begin
        first_reg <= 1'b0;
      end
      if ((state_reg == WAIT) && acc_done) begin
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
      if (step) begin
        plain_reg  <= plain_reg + ADDR_W'(BLOCK_STRIDE);
        cipher_reg <= cipher_reg + ADDR_W'(BLOCK_STRIDE);
      end
    end
  end

  // Registered accelerator strobes and job retirement pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_reg     <= 1'b0;
      start_key_reg <= 1'b0;
      job_done_reg  <= 1'b0;
    end else begin
      start_reg     <= (state_reg == ISSUE);
      start_key_reg <= (state_reg == ISSUE) && first_reg && new_key_reg;
      job_done_reg  <= finish;
    end
  end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Self-checking bench for aes_job_sequencer: a table of directed jobs,
// hand-written corner sequences and randomized jobs, all checked against an
// event-level reference model (expected start/done stream per job).
module tb_aes_job_sequencer;

  localparam int DEPTH  = 4;
  localparam int CW     = 8;
  localparam int STRIDE = 4;
  localparam int TO     = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [11:0]   job_plain_addr = '0;
  logic [11:0]   job_cipher_addr = '0;
  logic [CW-1:0] job_blocks = '0;
  logic          job_new_key = 1'b0;
  logic          acc_start, acc_new_key;
  logic [11:0]   acc_plain_address, acc_cipher_address;
  logic          acc_done;
  logic          job_done, busy, error;
  logic [$clog2(DEPTH):0] jobs_pending;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign acc_done = resp_done | spur_done;

  always #5 CLK = ~CLK;

  aes_job_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .CNT_W          (CW),
    .BLOCK_STRIDE   (STRIDE),
    .TIMEOUT_CYCLES (TO)
  ) uut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .job_valid          (job_valid),
    .job_ready          (job_ready),
    .job_plain_addr     (job_plain_addr),
    .job_cipher_addr    (job_cipher_addr),
    .job_blocks         (job_blocks),
    .job_new_key        (job_new_key),
    .acc_start          (acc_start),
    .acc_new_key        (acc_new_key),
    .acc_plain_address  (acc_plain_address),
    .acc_cipher_address (acc_cipher_address),
    .acc_done           (acc_done),
    .job_done           (job_done),
    .busy               (busy),
    .jobs_pending       (jobs_pending),
    .error              (error)
  );

  typedef struct packed {
    logic        is_done;
    logic [11:0] plain;
    logic [11:0] cipher;
    logic        nk;
    logic        err;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  obs_cyc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lone_err = 0;
  int stray_nk = 0;

  int done_delay = 10;
  bit withhold   = 1'b0;
  int cd         = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Accelerator model: answers each start with a done pulse done_delay cycles later.
  always @(negedge CLK) begin
    resp_done = 1'b0;
    if (!RST_N) begin
      cd = -1;
    end else begin
      if (cd > 0) cd--;
      if (cd == 0) begin
        resp_done = 1'b1;
        cd = -1;
      end
      if (acc_start && !withhold) cd = done_delay;
    end
  end

  // Monitor: records every start and job retirement in order.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (acc_start) begin
        obs_q.push_back(ev_t'{1'b0, acc_plain_address, acc_cipher_address, acc_new_key, 1'b0});
        obs_cyc.push_back(cyc);
        $display("[%0d] start plain=%03h cipher=%03h new_key=%0b", cyc, acc_plain_address, acc_cipher_address, acc_new_key);
      end
      if (job_done) begin
        obs_q.push_back(ev_t'{1'b1, 12'h000, 12'h000, 1'b0, error});
        obs_cyc.push_back(cyc);
        $display("[%0d] job_done error=%0b", cyc, error);
      end
      if (error && !job_done) lone_err++;
      if (acc_new_key && !acc_start) stray_nk++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a job yields one start per block at base + i*stride
  // (mod 4096), new_key on the first block only, then one clean job_done.
  task automatic model_add(input int p, input int c, input int b, input bit nk);
    for (int i = 0; i < b; i++) begin
      exp_q.push_back(ev_t'{1'b0, 12'((p + i * STRIDE) % 4096), 12'((c + i * STRIDE) % 4096),
                            (i == 0) ? nk : 1'b0, 1'b0});
    end
    exp_q.push_back(ev_t'{1'b1, 12'h000, 12'h000, 1'b0, 1'b0});
  endtask

  task automatic push_job(input int p, input int c, input int b, input bit nk, input bit add_model);
    int w;
    @(negedge CLK);
    job_valid       = 1'b1;
    job_plain_addr  = 12'(p);
    job_cipher_addr = 12'(c);
    job_blocks      = CW'(b);
    job_new_key     = nk;
    w = 0;
    while (!job_ready && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    if (!job_ready) begin
      check("push_ready_wait", 64'(job_ready), 64'd1);
      job_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1 job_valid = 1'b0;
      $display("[%0d] push plain=%03h cipher=%03h blocks=%0d new_key=%0b", cyc, p, c, b, nk);
      if (add_model) model_add(p, c, b, nk);
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((busy || jobs_pending != 0 || cd >= 0) && w < 5000) begin
      @(negedge CLK);
      w++;
    end
    check({name, "_idle_reached"}, 64'(w < 5000), 64'd1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_start(input string name);
    int w;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!acc_start && w < 300);
    check({name, "_start_seen"}, 64'(acc_start), 64'd1);
  endtask

  task automatic compare_logs(input string name);
    check({name, "_event_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_event%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int          p;
    int          c;
    int          b;
    bit          nk;
    int          exp_starts;
    logic [11:0] last_p;
    logic [11:0] last_c;
    bit          exp_first_nk;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int scyc[$];
    int dcyc, dones, nks, k;
    bit found;
    logic first_nk;
    logic [11:0] lp, lc;

    tbl[0] = '{32'h100, 32'h200, 3, 1'b1, 3, 12'h108, 12'h208, 1'b1};
    tbl[1] = '{32'hFFC, 32'h7FC, 2, 1'b0, 2, 12'h000, 12'h800, 1'b0};
    tbl[2] = '{32'h010, 32'h020, 0, 1'b1, 0, 12'h000, 12'h000, 1'b0};
    tbl[3] = '{32'hFF8, 32'hFF0, 5, 1'b1, 5, 12'h008, 12'h000, 1'b1};
    tbl[4] = '{32'h3A0, 32'h000, 1, 1'b1, 1, 12'h3A0, 12'h000, 1'b1};

    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_acc_start", 64'(acc_start), 64'd0);
    check("rst_acc_new_key", 64'(acc_new_key), 64'd0);
    check("rst_job_done", 64'(job_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_pending", 64'(jobs_pending), 64'd0);
    check("rst_plain", 64'(acc_plain_address), 64'h000);
    check("rst_cipher", 64'(acc_cipher_address), 64'h000);
    check("rst_ready", 64'(job_ready), 64'd1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed job table.
    done_delay = 10;
    for (int i = 0; i < 5; i++) begin
      push_job(tbl[i].p, tbl[i].c, tbl[i].b, tbl[i].nk, 1'b1);
      wait_idle($sformatf("tbl%0d", i));
      scyc.delete();
      dones = 0; nks = 0; dcyc = 0; first_nk = 1'b0; lp = '0; lc = '0;
      for (int j = 0; j < obs_q.size(); j++) begin
        if (obs_q[j].is_done) begin
          dones++;
          dcyc = obs_cyc[j];
        end else begin
          if (scyc.size() == 0) first_nk = obs_q[j].nk;
          scyc.push_back(obs_cyc[j]);
          if (obs_q[j].nk) nks++;
          lp = obs_q[j].plain;
          lc = obs_q[j].cipher;
        end
      end
      check($sformatf("tbl%0d_starts", i), 64'(scyc.size()), 64'(tbl[i].exp_starts));
      check($sformatf("tbl%0d_dones", i), 64'(dones), 64'd1);
      if (tbl[i].exp_starts > 0) begin
        check($sformatf("tbl%0d_last_plain", i), 64'(lp), 64'(tbl[i].last_p));
        check($sformatf("tbl%0d_last_cipher", i), 64'(lc), 64'(tbl[i].last_c));
        check($sformatf("tbl%0d_first_new_key", i), 64'(first_nk), 64'(tbl[i].exp_first_nk));
        check($sformatf("tbl%0d_new_key_count", i), 64'(nks), 64'(tbl[i].exp_first_nk));
        if (scyc.size() > 0) begin
          check($sformatf("tbl%0d_done_gap", i), 64'(dcyc - scyc[scyc.size()-1]), 64'(done_delay + 1));
        end
        for (int j = 1; j < scyc.size(); j++) begin
          check($sformatf("tbl%0d_turnaround%0d", i, j), 64'(scyc[j] - scyc[j-1]), 64'(done_delay + 2));
        end
      end
      compare_logs($sformatf("tbl%0d", i));
    end

    // Start latency, with a spurious done injected while the FSM is in ISSUE.
    @(negedge CLK);
    job_valid = 1'b1; job_plain_addr = 12'h040; job_cipher_addr = 12'h080;
    job_blocks = CW'(2); job_new_key = 1'b0;
    @(posedge CLK);
    #1 job_valid = 1'b0;
    model_add(32'h040, 32'h080, 2, 1'b0);
    k = -1; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      spur_done = (i == 2);
      if (i == 0) begin
        check("lat_pending_after_push", 64'(jobs_pending), 64'd1);
        check("lat_idle_after_push", 64'(busy), 64'd0);
      end
      if (i == 1) check("lat_busy_after_pop", 64'(busy), 64'd1);
      if (acc_start) begin
        found = 1'b1;
        k = i;
      end
    end
    spur_done = 1'b0;
    check("lat_start_cycle", 64'(k), 64'd3);
    wait_idle("lat");
    compare_logs("lat");

    // Spurious done while idle.
    @(negedge CLK) spur_done = 1'b1;
    @(negedge CLK) spur_done = 1'b0;
    repeat (5) @(negedge CLK);
    check("idle_spur_busy", 64'(busy), 64'd0);
    check("idle_spur_events", 64'(obs_q.size()), 64'd0);

    // Back-pressure: FSM busy, then five jobs at depth four.
    done_delay = 10;
    push_job(32'h500, 32'h600, 2, 1'b0, 1'b1);
    wait_start("bp");
    for (int i = 1; i <= 4; i++) push_job(32'h010 * i, 32'h020 * i, 1 + (i % 2), i[0], 1'b1);
    @(negedge CLK);
    check("bp_ready_full", 64'(job_ready), 64'd0);
    check("bp_pending_full", 64'(jobs_pending), 64'd4);
    push_job(32'h0A0, 32'h0B0, 1, 1'b1, 1'b1);
    @(negedge CLK);
    check("bp_fifth_pending", 64'(jobs_pending), 64'd4);
    wait_idle("bp");
    compare_logs("bp");

    // Reset during WAIT of a three-block job with another job queued.
    push_job(32'h700, 32'h710, 3, 1'b1, 1'b0);
    push_job(32'h720, 32'h730, 1, 1'b0, 1'b0);
    wait_start("rst");
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("mid_rst_start", 64'(acc_start), 64'd0);
    check("mid_rst_job_done", 64'(job_done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    check("mid_rst_pending", 64'(jobs_pending), 64'd0);
    check("mid_rst_addr", 64'({acc_plain_address, acc_cipher_address}), 64'd0);
    check("mid_rst_ready", 64'(job_ready), 64'd1);
    repeat (3) @(negedge CLK);
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    check("post_rst_events", 64'(obs_q.size()), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    obs_q.delete(); obs_cyc.delete();

    // Randomized jobs against the reference model.
    for (int i = 0; i < 12; i++) begin
      done_delay = $urandom_range(1, 6);
      push_job($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle("rnd");
    compare_logs("rnd");

`ifdef AES_SEQ_TIMEOUT_EN
    // Watchdog: withheld done aborts the job, next queued job runs normally.
    done_delay = 5;
    withhold = 1'b1;
    push_job(32'h900, 32'h910, 3, 1'b1, 1'b0);
    exp_q.push_back(ev_t'{1'b0, 12'h900, 12'h910, 1'b1, 1'b0});
    exp_q.push_back(ev_t'{1'b1, 12'h000, 12'h000, 1'b0, 1'b1});
    push_job(32'h920, 32'h930, 2, 1'b0, 1'b1);
    wait_start("wd");
    repeat (2) @(negedge CLK);
    withhold = 1'b0;
    wait_idle("wd");
    if (obs_cyc.size() >= 2) check("wd_abort_gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'(TO));
    compare_logs("wd");
    @(negedge CLK) spur_done = 1'b1;
    @(negedge CLK) spur_done = 1'b0;
    repeat (5) @(negedge CLK);
    check("wd_stray_done_events", 64'(obs_q.size()), 64'd0);
`endif

    check("error_without_job_done", 64'(lone_err), 64'd0);
    check("new_key_without_start", 64'(stray_nk), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got still running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
